// File: rtl/execute_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the Execute phase: shift-add multiply,
// restoring divide, one-cycle sign fix-up, and a stall that holds the phase while busy.
module execute_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_execute,
  input  logic            md_en,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  output logic            stall_md,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result,
  output logic [1:0]      state_dbg
);

  // Handshake: a start is taken in any IDLE cycle with phase_execute & md_en; stall_md is
  // high from that cycle through FIX, and md_valid pulses for one cycle in DONE with stall_md low.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_f3;
  logic              res_neg, rem_neg;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   opnd, acc_hi, acc_lo;

  logic              start, is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign start    = (state == IDLE) && phase_execute && md_en;
  assign is_div   = funct3[2];
  assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign b_signed = a_signed && (funct3 != 3'b010);
  assign a_neg    = a_signed && rs1data[XLEN-1];
  assign b_neg    = b_signed && rs2data[XLEN-1];
  assign a_mag    = a_neg ? -rs1data : rs1data;
  assign b_mag    = b_neg ? -rs2data : rs2data;

  // Cases with a fixed architectural answer skip the iteration entirely.
  assign div_zero = is_div && (rs2data == '0);
  assign div_ovf  = is_div && !funct3[0] && (rs1data == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (rs2data == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? rs1data : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : rs1data;
  end

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and fills with product bits.
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {XLEN{1'b0}})};
  // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

  assign prod_fix = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix = res_neg ? -acc_lo : acc_lo;
  assign rem_fix  = rem_neg ? -acc_hi : acc_hi;

  always_comb begin
    fix_res = '0;
    case (op_f3)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_f3     <= '0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      cnt       <= '0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      md_result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_f3   <= funct3;
          res_neg <= a_neg ^ b_neg;
          rem_neg <= a_neg;
          cnt     <= special ? '0 : CNT_W'(XLEN);
          acc_hi  <= '0;
          opnd    <= is_div ? b_mag : a_mag;
          acc_lo  <= is_div ? a_mag : b_mag;
          if (special) md_result <= special_res;
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (op_f3[2]) begin
            if (!div_diff[XLEN+1]) begin
              acc_hi <= div_diff[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
          end
        end
        FIX: md_result <= fix_res;
        default: ;
      endcase
    end
  end

  assign stall_md  = start || (state == CALC) || (state == FIX);
  assign md_valid  = (state == DONE);
  assign state_dbg = state;

endmodule

// File: doc/execute_muldiv_seq.md
# execute_muldiv_seq

Iterative sequencer for RV32M multiply/divide in the Execute phase. It accepts an M-extension operation while the core state machine is in the execute phase and holds the phase with a stall for the duration. It runs a shift-add multiply or a restoring divide over XLEN cycles, applies sign correction, and presents a result for the Execute latch. Its stall output is ORed into the Execute stage stall toward the state machine. Its result is muxed over the ALU output when the decoded op is M-type.

## Interface
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width (clog2(XLEN)+1)

- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- phase_execute  in  1  core state machine is in execute phase
- md_en  in  1  decoded op is an M-extension instruction
- funct3  in  3  M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1data  in  XLEN  operand A (multiplicand/dividend)
- rs2data  in  XLEN  operand B (multiplier/divisor)
- stall_md  out  1  hold the execute phase; combinational
- md_valid  out  1  result valid; one-cycle pulse
- md_result  out  XLEN  result; held until next start

## Operation
- States: IDLE, CALC, FIX, DONE.
- **Start condition:** IDLE and phase_execute=1 and md_en=1. On a start:
  - Latch funct3, operand signs, |A| and |B| (magnitudes are taken only for signed operands per funct3), and the counter.
  - stall_md=1 in the start cycle.
- **Special cases**, detected at start and sent directly IDLE→DONE:
  - Divide by zero, B=0: DIV/DIVU quotient = all ones; REM/REMU result = A.
  - Signed overflow, DIV with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000; REM result = 0.
- **Multiply:** unsigned shift-add on magnitudes into a 2*XLEN product, 1 bit per CALC cycle, XLEN cycles.
- **Divide:** restoring, 1 quotient bit per CALC cycle, XLEN cycles.
- **FIX:** one cycle of sign correction.
  - Product negated if the operand signs differ, for signed variants only.
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
  - Select low/high half or quotient/remainder per funct3.
  - Load md_result.
- **DONE:** md_valid=1, stall_md=0. Next state is always IDLE. No new start is accepted in the DONE cycle, even if phase_execute and md_en are still high.
- md_en, funct3 and operands are ignored after the start cycle. Changes mid-operation have no effect.
- phase_execute dropping mid-operation does not abort; the sequence completes.
- stall_md = (IDLE & phase_execute & md_en) | CALC | FIX.
- Reset mid-operation aborts immediately: state IDLE, all outputs at their reset values.

## Timing
- Reset values: state IDLE, md_valid 0, md_result 0, stall_md 0, counter 0, internal accumulators 0.
- Normal op, with start at cycle 0:
  - cycles 1..XLEN: CALC
  - cycle XLEN+1: FIX
  - cycle XLEN+2: DONE (md_valid=1, md_result valid)
  - stall_md=1 for cycles 0..XLEN+1 (34 cycles at XLEN=32)
- Special case:
  - cycle 1: DONE with md_valid=1
  - stall_md=1 in cycle 0 only
- md_result is registered and stays stable from DONE until the FIX (or special-case start) of the next operation.
- The Execute latch captures md_result in the DONE cycle, when phase_execute=1 and stall_md=0.
- Back-to-back starts: earliest next start is the cycle after DONE.

## Test plan
- MUL 7 × 0xFFFFFFFD → md_result 0xFFFFFFEB, md_valid at cycle 34; stall_md high cycles 0–33 and low at 34.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF
  - DIVU 100 / 7 → 14
  - REMU 100 / 7 → 2
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF at cycle 1
  - REM 5/0 → 5
- Signed overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1
  - REM of the same operands → 0
- Reset and start gating:
  - Assert rst_n=0 at cycle 10 of a MUL → stall_md, md_valid, md_result = 0 immediately; after release, a new DIVU 9/3 → 3 at cycle 34.
  - Hold phase_execute and md_en high through DONE → exactly one md_valid pulse, no restart.
